// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
// Contents:
//   MULT_NBITS   - default operand width / iteration count
//   seq_state_t  - sequencer state encoding
//   cnt_width()  - width of the iteration counter for a given NBITS
package mult_pkg;

    localparam int unsigned MULT_NBITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        DONE
    } seq_state_t;

    // Counter must hold 0..nbits-1; keep at least one bit for degenerate widths.
    function automatic int unsigned cnt_width(input int unsigned nbits);
        return (nbits < 2) ? 1 : $clog2(nbits);
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Control bundle between the board inputs, the sequencer and the register unit.
// Signals:
//   Run, ClearA_LoadB, M                       - into the sequencer
//   Clr_ld, ClrAX, Shift, Add, Sub, Busy, Done - out of the sequencer
// Modports:
//   master - the sequencer
//   slave  - the environment (buttons/switches and datapath)
interface mult_sequencer_if;

    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clr_ld;
    logic ClrAX;
    logic Shift;
    logic Add;
    logic Sub;
    logic Busy;
    logic Done;

    modport master (
        input  Run, ClearA_LoadB, M,
        output Clr_ld, ClrAX, Shift, Add, Sub, Busy, Done
    );

    modport slave (
        output Run, ClearA_LoadB, M,
        input  Clr_ld, ClrAX, Shift, Add, Sub, Busy, Done
    );

endinterface

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier loop: counts 0..NBITS-1.
// Ports:
//   Clk, Reset - clock, asynchronous active-high reset (clears count)
//   clr        - synchronous clear to 0 (wins over en)
//   en         - increment by one
//   tc         - terminal count, high when count == NBITS-1
module iter_counter
    import mult_pkg::*;
#(
    parameter int unsigned NBITS = MULT_NBITS
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = cnt_width(NBITS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(NBITS - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Counter-based ADD/SHIFT sequencer for the 8-bit signed shift-add multiplier.
// Ports:
//   Clk, Reset - clock, asynchronous active-high reset (returns to IDLE)
//   bus        - mult_sequencer_if.master: Run/ClearA_LoadB/M in,
//                Clr_ld/ClrAX/Shift/Add/Sub/Busy/Done out
// Sequence per press: START (clear A/X), then NBITS x {ADD, SHIFT}, then DONE
// until Run is released. The last ADD subtracts to weight the sign bit of B.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned NBITS = MULT_NBITS
) (
    input  logic              Clk,
    input  logic              Reset,
    mult_sequencer_if.master  bus
);

    seq_state_t state_q;
    seq_state_t state_d;

    logic cnt_clr;
    logic cnt_en;
    logic last_iter;

    // Restart the count on the press itself; hold it at NBITS-1 after the last shift.
    assign cnt_clr = (state_q == IDLE) && !bus.Run;
    assign cnt_en  = (state_q == SHIFT) && !last_iter;

    iter_counter #(
        .NBITS (NBITS)
    ) u_iter_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (last_iter)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!bus.Run) state_d = START;
            START:   state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = last_iter ? DONE : ADD;
            DONE:    if (bus.Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.Clr_ld = 1'b0;
        bus.ClrAX  = 1'b0;
        bus.Shift  = 1'b0;
        bus.Add    = 1'b0;
        bus.Sub    = 1'b0;
        bus.Busy   = 1'b0;
        bus.Done   = 1'b0;
        unique case (state_q)
            // Gating with Run drops the load in the cycle a press is seen.
            IDLE:  bus.Clr_ld = bus.ClearA_LoadB & bus.Run;
            START: begin
                bus.ClrAX = 1'b1;
                bus.Busy  = 1'b1;
            end
            ADD: begin
                bus.Add  = bus.M & !last_iter;
                bus.Sub  = bus.M & last_iter;
                bus.Busy = 1'b1;
            end
            SHIFT: begin
                bus.Shift = 1'b1;
                bus.Busy  = 1'b1;
            end
            DONE:    bus.Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer with a behavioural datapath.
module tb_mult_sequencer;

    logic Clk;
    logic Reset;

    mult_sequencer_if intf ();

    mult_sequencer #(
        .NBITS (8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (intf.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural register unit: X:A:B with 9-bit add/sub into X:A.
    logic [7:0] dp_a, dp_b, dp_s, sw;
    logic       dp_x;
    logic       use_dp;
    logic       m_force;

    assign intf.M = use_dp ? dp_b[0] : m_force;

    always @(posedge Clk) begin
        if (intf.Clr_ld) begin
            dp_b <= sw;
            dp_a <= 8'h00;
            dp_x <= 1'b0;
        end else if (intf.ClrAX) begin
            dp_a <= 8'h00;
            dp_x <= 1'b0;
        end else if (intf.Add) begin
            {dp_x, dp_a} <= {dp_a[7], dp_a} + {dp_s[7], dp_s};
        end else if (intf.Sub) begin
            {dp_x, dp_a} <= {dp_a[7], dp_a} - {dp_s[7], dp_s};
        end else if (intf.Shift) begin
            dp_a <= {dp_x, dp_a[7:1]};
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    // Per-operation observations
    int n_add, n_sub, n_shift, n_clrax, clrax_cyc, done_cyc;
    int n_overlap, n_multi, n_clrld, n_notbusy, busy_at_done;
    logic         pre_clrld;
    logic [127:0] sig;

    // Expected {Shift,Sub,Add} per cycle for NBITS=8 with M held at m.
    function automatic logic [127:0] exp_sig(input logic m);
        logic [127:0] s;
        s = '0;
        for (int c = 1; c <= 18; c++) begin
            if (c >= 2 && c <= 17 && (c % 2) == 0) begin
                if (c == 16) s[c*3+1] = m;
                else         s[c*3]   = m;
            end
            if (c >= 3 && c <= 17 && (c % 2) == 1) s[c*3+2] = 1'b1;
        end
        return s;
    endfunction

    // Press Run at a negedge (edge 0 follows) and observe cycles 1.. until Done.
    task automatic run_op(input logic cl_during);
        n_add = 0; n_sub = 0; n_shift = 0; n_clrax = 0; clrax_cyc = 0; done_cyc = 0;
        n_overlap = 0; n_multi = 0; n_clrld = 0; n_notbusy = 0; busy_at_done = 0;
        sig = '0;
        @(negedge Clk);
        intf.Run = 1'b0;
        intf.ClearA_LoadB = cl_during;
        #1 pre_clrld = intf.Clr_ld;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge Clk);
            if (intf.ClrAX) begin
                n_clrax++;
                clrax_cyc = c;
            end
            n_add   += int'(intf.Add);
            n_sub   += int'(intf.Sub);
            n_shift += int'(intf.Shift);
            n_clrld += int'(intf.Clr_ld);
            if (intf.Add && intf.Sub) n_overlap++;
            if (int'(intf.Clr_ld) + int'(intf.ClrAX) + int'(intf.Shift)
                + int'(intf.Add | intf.Sub) > 1) n_multi++;
            if (c <= 40) sig[c*3 +: 3] = {intf.Shift, intf.Sub, intf.Add};
            if (intf.Done) begin
                done_cyc = c;
                busy_at_done = int'(intf.Busy);
            end else if (!intf.Busy) begin
                n_notbusy++;
            end
        end
        intf.ClearA_LoadB = 1'b0;
    endtask

    task automatic check_op(input string tag, input int exp_add, input int exp_sub,
                            input logic m);
        logic [127:0] e;
        e = exp_sig(m);
        check({tag, "_done_cyc"}, done_cyc, 18);
        check({tag, "_adds"}, n_add, exp_add);
        check({tag, "_subs"}, n_sub, exp_sub);
        check({tag, "_shifts"}, n_shift, 8);
        check({tag, "_clrax_cnt"}, n_clrax, 1);
        check({tag, "_clrax_cyc"}, clrax_cyc, 1);
        check({tag, "_overlap"}, n_overlap, 0);
        check({tag, "_multi"}, n_multi, 0);
        check({tag, "_notbusy"}, n_notbusy, 0);
        check({tag, "_busy_done"}, busy_at_done, 0);
        for (int i = 0; i < 4; i++) check({tag, "_sig"}, sig[i*32 +: 32], e[i*32 +: 32]);
    endtask

    task automatic release_run(input string tag);
        @(negedge Clk);
        intf.Run = 1'b1;
        @(negedge Clk);
        check({tag, "_idle_done"}, intf.Done, 1'b0);
        check({tag, "_idle_busy"}, intf.Busy, 1'b0);
    endtask

    int held_done, held_busy, post_pulses;

    initial begin
        Reset = 1'b1;
        intf.Run = 1'b1;
        intf.ClearA_LoadB = 1'b1;
        use_dp = 1'b0;
        m_force = 1'b0;
        sw = 8'h00;
        dp_s = 8'h00;
        #2;
        check("rst_clrld", intf.Clr_ld, 1'b1);
        check("rst_busy", intf.Busy, 1'b0);
        check("rst_done", intf.Done, 1'b0);
        check("rst_strobes", {intf.ClrAX, intf.Shift, intf.Add, intf.Sub}, 4'b0);
        intf.ClearA_LoadB = 1'b0;
        #1 check("rst_clrld_off", intf.Clr_ld, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // M held 1
        m_force = 1'b1;
        run_op(1'b0);
        check_op("m1", 7, 1, 1'b1);

        // Held button never retriggers
        held_done = 0;
        held_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            held_done += int'(intf.Done);
            held_busy += int'(intf.Busy);
        end
        check("held_done", held_done, 10);
        check("held_busy", held_busy, 0);
        release_run("m1");

        // Second press gives the same sequence
        run_op(1'b0);
        check_op("m1_again", 7, 1, 1'b1);
        release_run("m1_again");

        // M held 0
        m_force = 1'b0;
        run_op(1'b0);
        check_op("m0", 0, 0, 1'b0);
        release_run("m0");

        // Load request in the press cycle and throughout Busy
        m_force = 1'b1;
        run_op(1'b1);
        check("press_load_clrld", pre_clrld, 1'b0);
        check("busy_load_clrld", n_clrld, 0);
        check_op("press_load", 7, 1, 1'b1);
        release_run("press_load");

        // Datapath: 7 x -3
        use_dp = 1'b1;
        sw = 8'h07;
        dp_s = 8'hFD;
        @(negedge Clk);
        intf.ClearA_LoadB = 1'b1;
        #1 check("load_clrld", intf.Clr_ld, 1'b1);
        @(negedge Clk);
        intf.ClearA_LoadB = 1'b0;
        run_op(1'b0);
        check("mul_7_m3", {dp_a, dp_b}, 16'hFFEB);
        check("mul_7_m3_done", done_cyc, 18);
        release_run("mul_7_m3");

        // Datapath: -128 x -128
        sw = 8'h80;
        dp_s = 8'h80;
        @(negedge Clk);
        intf.ClearA_LoadB = 1'b1;
        @(negedge Clk);
        intf.ClearA_LoadB = 1'b0;
        run_op(1'b0);
        check("mul_80_80", {dp_a, dp_b}, 16'h4000);
        release_run("mul_80_80");

        // Reset in cycle 7 of a multiply
        use_dp = 1'b0;
        m_force = 1'b1;
        @(negedge Clk);
        intf.Run = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge Clk);
        check("pre_rst_shift", intf.Shift, 1'b1);
        intf.Run = 1'b1;
        intf.ClearA_LoadB = 1'b1;
        #1 Reset = 1'b1;
        #1;
        check("midrst_busy", intf.Busy, 1'b0);
        check("midrst_strobes", {intf.ClrAX, intf.Shift, intf.Add, intf.Sub, intf.Done}, 5'b0);
        check("midrst_clrld", intf.Clr_ld, 1'b1);
        intf.ClearA_LoadB = 1'b0;
        post_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (i == 4) Reset = 1'b0;
            post_pulses += int'(intf.Shift) + int'(intf.Add) + int'(intf.Sub)
                           + int'(intf.Busy);
        end
        check("post_rst_pulses", post_pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Counter-based sequencer for the 8-bit signed shift-add multiplier datapath (A/B registers, sign bit X, 9-bit adder/subtractor). It replaces one-state-per-step control with a compact ADD/SHIFT loop driven by an iteration counter. It adds explicit start-of-operation clearing of A and X, a Busy/Done handshake, and press/release sequencing of the active-low Run pushbutton. It sits between the board switches/buttons and the register unit, and drives Clr_ld, ClrAX, Shift, Add and Sub.

## Interface
- NBITS, 8, multiplier operand width; number of add/shift iterations (must be ≥ 2)
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high; clock Clk
- Run  in  1  active-low start pushbutton (0 = pressed), already synchronized upstream
- ClearA_LoadB  in  1  active-high; while idle, load B from switches and clear A/X
- M  in  1  current multiplier LSB (B[0]) from the datapath
- Clr_ld  out  1  load B / clear A and X (idle only)
- ClrAX  out  1  clear A and X at start of multiply
- Shift  out  1  arithmetic right shift of X:A:B by one
- Add  out  1  A ← A + S (9-bit, sign-extended into X)
- Sub  out  1  A ← A − S (final iteration only)
- Busy  out  1  high from START through final SHIFT
- Done  out  1  high in DONE (result valid in A:B)

## Operation
- States: IDLE, START, ADD, SHIFT, DONE. Iteration counter cnt has width $clog2(NBITS) and runs 0..NBITS−1.
- IDLE:
  - Clr_ld = ClearA_LoadB & Run. A load is suppressed in the same cycle a press is seen.
  - Run==0 → START, cnt←0.
- START: ClrAX=1 for one cycle → ADD.
- ADD: this state performs either an add or a subtract, chosen by cnt.
  - cnt<NBITS−1: Add=M, Sub=0.
  - cnt==NBITS−1: Sub=M, Add=0.
  - Always → SHIFT.
- SHIFT: Shift=1.
  - cnt==NBITS−1 → DONE.
  - Otherwise cnt←cnt+1 → ADD.
- DONE: Done=1 and no datapath strobes. Run==1 (released) → IDLE. A held button never retriggers.
- Add and Sub are never both 1.
- At most one of {Clr_ld, ClrAX, Shift, Add|Sub} is high in any cycle.
- All outputs decode combinationally from the registered state, plus M / Run / ClearA_LoadB where listed above.
- Busy = state ∈ {START, ADD, SHIFT}.
- ClearA_LoadB is ignored outside IDLE.

## Timing
- Reset (asserted at any time, including mid-multiply): state←IDLE and cnt←0 immediately, independent of Clk.
  - While in reset: ClrAX, Shift, Add, Sub, Busy, Done = 0.
  - Clr_ld = ClearA_LoadB & Run.
  - No further Shift after Reset rises.
- Press sampled at edge 0 (IDLE→START):
  - ClrAX in cycle 1.
  - ADD/SHIFT pairs occupy cycles 2..2·NBITS+1.
  - Done first high in cycle 2·NBITS+2 (cycle 18 for NBITS=8).
- Exactly NBITS Shift pulses per operation.
- M is sampled in ADD cycles only, so the datapath must present the post-shift B[0] by then. Shift is registered in the datapath, so this holds.
- Release during Busy has no effect. Release in DONE returns to IDLE on the next edge; a re-press starts a new operation from IDLE.

## Structure
- Shared package mult_pkg:
  - state enum type seq_state_t {IDLE, START, ADD, SHIFT, DONE}.
  - localparam MULT_NBITS = 8.
  - counter width function.
- Sub-module iter_counter: NBITS-parameterised up-counter with clear, enable and terminal-count output (cnt==NBITS−1). The main module holds the state register and output decode.

## Test plan
- Reset mid-operation: assert Reset in cycle 7 of a multiply → same-cycle return to IDLE; Busy=0; no Shift or Add pulses afterwards.
- M held 1, press Run:
  - 7 Add pulses, then 1 Sub pulse, 8 Shift pulses.
  - ClrAX only in cycle 1; Done at cycle 18.
  - Add & Sub never coincide.
- M held 0, press Run: zero Add/Sub pulses, 8 Shift pulses, Done at cycle 18.
- Behavioural datapath, B=0x07 (after Clr_ld with switches 0x07), S=0xFD, press → A:B=0xFFEB (7 × −3 = −21).
  - Repeat with 0x80 × 0x80 → 0x4000.
- ClearA_LoadB=1 and Run pressed in the same IDLE cycle → Clr_ld=0, START entered.
  - ClearA_LoadB=1 during Busy → Clr_ld stays 0.
- Hold Run low past Done for 10 cycles → remains in DONE, no retrigger.
  - Release → IDLE; second press yields an identical pulse sequence.
